// File: rtl/mem_bist_initiator_if.sv
// Single-port memory bus between the BIST initiator (master) and the memory (slave).
// Read data is registered in the memory: mem_rdata is valid one cycle after mem_addr.
interface mem_bist_initiator_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: writes pattern(a) = a ^ SEED to every location, reads back and compares.
// Optional macro BIST_INV_PASS_EN adds a second write/read pass using ~pattern(a).
module mem_bist_initiator #(
  parameter int                ADDR_W = 7,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 128,
  parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  mem_bist_initiator_if.master mem,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [7:0]        err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [2:0]        dbg_state_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [7:0]        err_q;
  logic [ADDR_W-1:0] first_err_q;
  logic              rd_vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              inv_q;

  logic [CNT_W-1:0]  cnt_d;
  logic              cnt_last;
  logic              mismatch;
  logic [7:0]        err_d;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
    logic [DATA_W+ADDR_W-1:0] ext;
    logic [DATA_W-1:0]        p;
    ext = {{DATA_W{1'b0}}, a};
    p   = ext[DATA_W-1:0] ^ SEED;
    return inv ? ~p : p;
  endfunction

`ifndef BIST_INV_PASS_EN
  assign inv_q = 1'b0;
`endif

  assign cnt_d    = cnt_q + CNT_W'(1);
  assign cnt_last = (cnt_q == LAST);
  // rdata and exp_q both refer to the address presented one cycle earlier.
  assign mismatch = rd_vld_q && (mem.mem_rdata != exp_q);
  assign err_d    = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
      rd_vld_q    <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
`ifdef BIST_INV_PASS_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      rd_vld_q   <= (state_q == S_READ);
      exp_q      <= pattern(mem_addr_q, inv_q);
      cmp_addr_q <= mem_addr_q;

      if (mismatch) begin
        err_q <= err_d;
        if (err_q == 8'd0) first_err_q <= cmp_addr_q;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q     <= S_WRITE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= pattern('0, 1'b0);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
`ifdef BIST_INV_PASS_EN
            inv_q       <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (cnt_last) begin
            state_q     <= S_READ;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
          end else begin
            cnt_q       <= cnt_d;
            mem_addr_q  <= cnt_d[ADDR_W-1:0];
            mem_wdata_q <= pattern(cnt_d[ADDR_W-1:0], inv_q);
          end
        end
        S_READ: begin
          if (cnt_last) begin
            state_q <= S_DRAIN;
          end else begin
            cnt_q      <= cnt_d;
            mem_addr_q <= cnt_d[ADDR_W-1:0];
          end
        end
        S_DRAIN: begin
`ifdef BIST_INV_PASS_EN
          if (!inv_q) begin
            // Second pass with inverted data; error state carries over.
            state_q     <= S_WRITE;
            inv_q       <= 1'b1;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= pattern('0, 1'b1);
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
          end
`else
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_d == 8'd0);
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_addr     = mem_addr_q;
  assign mem.mem_wr       = mem_wr_q;
  assign mem.mem_wdata    = mem_wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Bench for mem_bist_initiator: behavioural memory with stuck-at faults, table vectors,
// timing sequences and randomized faults checked against a per-address reference model.
module tb_mem_bist_initiator;

`ifdef BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LAT     = NPASS * 257;
  localparam int ERR_FF  = (NPASS == 2) ? 255 : 127;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [6:0] first_err;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  mem_bist_initiator_if #(.ADDR_W(7), .DATA_W(8)) mif ();

  mem_bist_initiator dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .mem              (mif),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err),
    .dbg_state_o      (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // memory model with per-address stuck-at read faults
  logic [7:0] mem_arr [0:127];
  bit         stuck_en [0:127];
  logic [7:0] stuck_val [0:127];

  always @(posedge clk) begin
    if (mif.mem_wr) mem_arr[mif.mem_addr] <= mif.mem_wdata;
    mif.mem_rdata <= stuck_en[mif.mem_addr] ? stuck_val[mif.mem_addr] : mem_arr[mif.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pat(input int a, input int p);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    return (p == 1) ? ~v : v;
  endfunction

  // scoreboard: expected values per test pushed here, popped after the run
  logic [31:0] exp_q[$];

  function automatic void model_push();
    int cnt   = 0;
    int first = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < 128; a++) begin
        logic [7:0] wv, rv;
        wv = ref_pat(a, p);
        rv = stuck_en[a] ? stuck_val[a] : wv;
        if (rv != wv) begin
          if (cnt == 0) first = a;
          if (cnt < 255) cnt++;
        end
      end
    end
    exp_q.push_back(32'(cnt == 0));
    exp_q.push_back(32'(cnt));
    exp_q.push_back(32'(first));
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < 128; i++) begin
      stuck_en[i]  = 1'b0;
      stuck_val[i] = 8'h00;
    end
  endtask

  task automatic set_mode(input int mode);
    clear_faults();
    if (mode == 1) begin
      stuck_en[16]  = 1'b1;
      stuck_val[16] = 8'h00;
    end else if (mode == 2) begin
      for (int i = 0; i < 128; i++) begin
        stuck_en[i]  = 1'b1;
        stuck_val[i] = 8'hFF;
      end
    end
  endtask

  // driver: start pulse (or held start), then wait for done with a cycle budget
  task automatic run_bist(input bit hold, output int lat);
    int busy_gaps = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = -1;
    for (int k = 0; k < 1200; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_gaps++;
      if (k == 5) begin
        check("wr_at_n6", 32'(mif.mem_wr), 32'd1);
        check("addr_at_n6", 32'(mif.mem_addr), 32'd5);
        check("wdata_at_n6", 32'(mif.mem_wdata), 32'hA0);
      end
`ifdef BIST_INV_PASS_EN
      if (k == 260) begin
        check("inv_addr3", 32'(mif.mem_addr), 32'd3);
        check("inv_wdata3", 32'(mif.mem_wdata), 32'h59);
      end
`endif
      @(posedge clk); #1;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("busy_span", 32'(busy_gaps), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    check("wr_at_done", 32'(mif.mem_wr), 32'd0);
    check("wdata_at_done", 32'(mif.mem_wdata), 32'd0);
  endtask

  typedef struct {
    int mode;
    bit exp_pass;
    int exp_err;
    int exp_first;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int lat;
    logic [31:0] e;

    vecs[0] = '{mode: 0, exp_pass: 1'b1, exp_err: 0,      exp_first: 0};
    vecs[1] = '{mode: 1, exp_pass: 1'b0, exp_err: NPASS,  exp_first: 16};
    vecs[2] = '{mode: 2, exp_pass: 1'b0, exp_err: ERR_FF, exp_first: 0};

    clear_faults();
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_first", 32'(first_err), 32'd0);
      check("rst_wr", 32'(mif.mem_wr), 32'd0);
      check("rst_addr", 32'(mif.mem_addr), 32'd0);
      check("rst_wdata", 32'(mif.mem_wdata), 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 3; i++) begin
      set_mode(vecs[i].mode);
      run_bist(1'b0, lat);
      check("vec_done", 32'(done), 32'd1);
      check("vec_pass", 32'(pass), 32'(vecs[i].exp_pass));
      check("vec_err", 32'(err_count), 32'(vecs[i].exp_err));
      check("vec_first", 32'(first_err), 32'(vecs[i].exp_first));
      check("vec_addr_hold", 32'(mif.mem_addr), 32'd127);
    end

    // held start: one full test, then an immediate restart from DONE, then rst mid-test
    set_mode(0);
    run_bist(1'b1, lat);
    check("held_pass", 32'(pass), 32'd1);
    @(posedge clk); #1;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_wr", 32'(mif.mem_wr), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr", 32'(mif.mem_wr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_done", 32'(done), 32'd0);

    // randomized stuck-at faults against the reference model
    for (int it = 0; it < 5; it++) begin
      int n;
      clear_faults();
      n = $urandom_range(0, 8);
      for (int j = 0; j < n; j++) begin
        int a;
        a = $urandom_range(0, 127);
        stuck_en[a]  = 1'b1;
        stuck_val[a] = ($urandom_range(0, 3) == 0) ? ref_pat(a, 0) : 8'($urandom_range(0, 255));
      end
      model_push();
      run_bist(1'b0, lat);
      e = exp_q.pop_front();
      check("rnd_pass", 32'(pass), e);
      e = exp_q.pop_front();
      check("rnd_err", 32'(err_count), e);
      e = exp_q.pop_front();
      check("rnd_first", 32'(first_err), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
